// File: rtl/ccip_sum_reader_pkg.sv
// Shared types and constants for the CCI-P c0 line-sum read engine.
package ccip_sum_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } t_state;

  localparam int OP_W    = 64;
  localparam int OPA_LSB = 0;
  localparam int OPB_LSB = 64;
  localparam int MDATA_W = 16;
  localparam int LINE_W  = 512;

endpackage

// File: rtl/ccip_rd_credit_ctr.sv
// Tracks read requests in flight and gates new requests at MAX_OUTSTANDING.
module ccip_rd_credit_ctr #(
  parameter  int MAX_OUTSTANDING = 32,
  localparam int OCNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              inc,
  input  logic              dec,
  output logic [OCNT_W-1:0] outstanding,
  output logic              can_issue
);

  // A simultaneous issue and response leave the count unchanged.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      outstanding <= '0;
    end else if (inc && !dec) begin
      outstanding <= outstanding + OCNT_W'(1);
    end else if (dec && !inc) begin
      outstanding <= outstanding - OCNT_W'(1);
    end
  end

  assign can_issue = (outstanding < OCNT_W'(MAX_OUTSTANDING));

endmodule

// File: rtl/ccip_sum_line_reader.sv
// CCI-P c0 read engine: fetches num_lines lines from base_addr and sums operand pairs.
module ccip_sum_line_reader
  import ccip_sum_reader_pkg::*;
#(
  parameter int ADDR_W          = 42,
  parameter int CNT_W           = 16,
  parameter int MAX_OUTSTANDING = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [CNT_W-1:0]   num_lines,
  output logic               c0_tx_valid,
  output logic [ADDR_W-1:0]  c0_tx_addr,
  output logic [MDATA_W-1:0] c0_tx_mdata,
  input  logic               c0TxAlmFull,
  input  logic               c0_rsp_valid,
  input  logic [LINE_W-1:0]  c0_rsp_data,
  output logic               busy,
  output logic               done,
  output logic [OP_W-1:0]    sum,
  output logic               overflow
);

  localparam int OCNT_W = $clog2(MAX_OUTSTANDING + 1);

  t_state              state;
  t_state              state_next;
  logic [ADDR_W-1:0]   base_r;
  logic [CNT_W-1:0]    num_r;
  logic [CNT_W-1:0]    req_cnt;
  logic [CNT_W-1:0]    rsp_cnt;
  logic                issue;
  logic                start_ok;
  logic                rsp_ok;
  logic                can_issue;
  logic [OCNT_W-1:0]   outstanding;
  logic [OP_W+1:0]     acc_next;
  logic                unused_rsp_hi;

  // Two extra bits keep both carries of the three-way add visible.
  function automatic logic [OP_W+1:0] add3(input logic [OP_W-1:0] s,
                                           input logic [OP_W-1:0] a,
                                           input logic [OP_W-1:0] b);
    return {2'b00, s} + {2'b00, a} + {2'b00, b};
  endfunction

  ccip_rd_credit_ctr #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_credit (
    .clk         (clk),
    .reset_n     (reset_n),
    .inc         (issue),
    .dec         (rsp_ok),
    .outstanding (outstanding),
    .can_issue   (can_issue)
  );

  assign start_ok      = (state == IDLE) && start;
  assign rsp_ok        = c0_rsp_valid && ((state == REQ) || (state == DRAIN));
  assign busy          = (state == REQ) || (state == DRAIN);
  assign acc_next      = add3(sum, c0_rsp_data[OPA_LSB +: OP_W], c0_rsp_data[OPB_LSB +: OP_W]);
  assign unused_rsp_hi = ^c0_rsp_data[LINE_W-1:OPB_LSB+OP_W];

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = (num_lines == '0) ? DONE : REQ;
      end
      REQ: begin
        issue = !c0TxAlmFull && can_issue;
        if (issue && (req_cnt == num_r - CNT_W'(1))) state_next = DRAIN;
      end
      DRAIN: begin
        if (rsp_cnt == num_r) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Stage p0: request issue, response accumulation and control registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      base_r      <= '0;
      num_r       <= '0;
      req_cnt     <= '0;
      rsp_cnt     <= '0;
      c0_tx_valid <= 1'b0;
      c0_tx_addr  <= '0;
      c0_tx_mdata <= '0;
      done        <= 1'b0;
      sum         <= '0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_next;
      done        <= (state == DONE);
      c0_tx_valid <= issue;
      if (issue) begin
        c0_tx_addr  <= base_r + ADDR_W'(req_cnt);
        c0_tx_mdata <= MDATA_W'(req_cnt);
        req_cnt     <= req_cnt + CNT_W'(1);
      end
      if (start_ok) begin
        base_r   <= base_addr;
        num_r    <= num_lines;
        req_cnt  <= '0;
        rsp_cnt  <= '0;
        sum      <= '0;
        overflow <= 1'b0;
      end else if (rsp_ok) begin
        sum      <= acc_next[OP_W-1:0];
        overflow <= overflow | (acc_next[OP_W+1:OP_W] != 2'b00);
        rsp_cnt  <= rsp_cnt + CNT_W'(1);
      end
    end
  end

  rsp_bound_a: assert property (@(posedge clk) disable iff (!reset_n)
    rsp_ok |-> (rsp_cnt < num_r));

  credit_bound_a: assert property (@(posedge clk) disable iff (!reset_n)
    outstanding <= OCNT_W'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_ccip_sum_line_reader.sv
// Directed bench for ccip_sum_line_reader with a small host-memory responder.
module tb_ccip_sum_line_reader;

  localparam int ADDR_W = 42;
  localparam int CNT_W  = 16;
  localparam int MAX_OS = 32;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  num_lines;
  logic              c0_tx_valid;
  logic [ADDR_W-1:0] c0_tx_addr;
  logic [15:0]       c0_tx_mdata;
  logic              c0TxAlmFull;
  logic              c0_rsp_valid;
  logic [511:0]      c0_rsp_data;
  logic              busy;
  logic              done;
  logic [63:0]       sum;
  logic              overflow;

  int n_checks = 0;
  int n_errors = 0;

  logic [ADDR_W-1:0] req_addr_q[$];
  logic [15:0]       req_tag_q[$];
  int                req_total = 0;
  int                done_cnt  = 0;

  ccip_sum_line_reader #(
    .ADDR_W          (ADDR_W),
    .CNT_W           (CNT_W),
    .MAX_OUTSTANDING (MAX_OS)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .base_addr    (base_addr),
    .num_lines    (num_lines),
    .c0_tx_valid  (c0_tx_valid),
    .c0_tx_addr   (c0_tx_addr),
    .c0_tx_mdata  (c0_tx_mdata),
    .c0TxAlmFull  (c0TxAlmFull),
    .c0_rsp_valid (c0_rsp_valid),
    .c0_rsp_data  (c0_rsp_data),
    .busy         (busy),
    .done         (done),
    .sum          (sum),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  // Request/done monitor samples 1 ns after each rising edge.
  always @(posedge clk) begin
    #1;
    if (c0_tx_valid) begin
      req_addr_q.push_back(c0_tx_addr);
      req_tag_q.push_back(c0_tx_mdata);
      req_total++;
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] n);
    base_addr = b;
    num_lines = n;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic send_rsp(input logic [63:0] a, input logic [63:0] b);
    c0_rsp_data  = {{384{1'b1}}, b, a};
    c0_rsp_valid = 1'b1;
    @(negedge clk);
    c0_rsp_valid = 1'b0;
    c0_rsp_data  = '0;
  endtask

  task automatic wait_reqs(input int target, input int budget, input string tag);
    int k = 0;
    while (req_total < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 64'(req_total >= target), 64'd1);
  endtask

  task automatic wait_done(input int d0, input int budget, input string tag);
    int k = 0;
    while (done_cnt == d0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 64'(done_cnt != d0), 64'd1);
  endtask

  initial begin
    int r0, r1, d0, bad, k, max_inf, inf;
    logic [ADDR_W-1:0] idx;
    logic [63:0] la [3];
    logic [63:0] lb [3];

    reset_n = 1'b0; start = 1'b0; base_addr = '0; num_lines = '0;
    c0TxAlmFull = 1'b0; c0_rsp_valid = 1'b0; c0_rsp_data = '0;
    tick(3);
    chk("rst_valid", 64'(c0_tx_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sum", sum, 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_addr", 64'(c0_tx_addr), 64'd0);
    chk("rst_tag", 64'(c0_tx_mdata), 64'd0);
    reset_n = 1'b1;
    tick(2);

    // T1: four lines, in-order responses, sum 36
    r0 = req_total; d0 = done_cnt;
    do_start(42'h1000, 16'd4);
    chk("t1_valid_cycle1", 64'(c0_tx_valid), 64'd0);
    chk("t1_busy", 64'(busy), 64'd1);
    tick();
    chk("t1_valid_cycle2", 64'(c0_tx_valid), 64'd1);
    chk("t1_first_addr", 64'(c0_tx_addr), 64'h1000);
    wait_reqs(r0 + 4, 20, "t1_reqs");
    tick(3);
    chk("t1_req_count", 64'(req_total - r0), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_addr", 64'(req_addr_q[r0 + i]), 64'h1000 + 64'(i));
      chk("t1_tag", 64'(req_tag_q[r0 + i]), 64'(i));
    end
    for (int i = 0; i < 4; i++) send_rsp(64'(2 * i + 1), 64'(2 * i + 2));
    wait_done(d0, 20, "t1_done_seen");
    tick(3);
    chk("t1_sum", sum, 64'd36);
    chk("t1_ovf", 64'(overflow), 64'd0);
    chk("t1_done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("t1_busy_end", 64'(busy), 64'd0);

    // T2: zero lines, done two cycles after start, sum cleared
    r0 = req_total; d0 = done_cnt;
    do_start(42'h1234, 16'd0);
    chk("t2_done_c1", 64'(done), 64'd0);
    tick();
    chk("t2_done_c2", 64'(done), 64'd1);
    tick();
    chk("t2_done_c3", 64'(done), 64'd0);
    tick(5);
    chk("t2_no_req", 64'(req_total - r0), 64'd0);
    chk("t2_sum", sum, 64'd0);
    chk("t2_done_pulses", 64'(done_cnt - d0), 64'd1);

    // T3: 100 lines with responses held back, then released one per cycle
    r0 = req_total; d0 = done_cnt;
    do_start(42'h2000, 16'd100);
    tick(60);
    chk("t3_held_inflight", 64'(req_total - r0), 64'd32);
    bad = 0; max_inf = 0;
    for (int i = 0; i < 100; i++) begin
      k = 0;
      while (req_total - r0 <= i && k < 50) begin tick(); k++; end
      if (req_total - r0 <= i) begin
        chk("t3_req_timeout", 64'(req_total - r0), 64'(i + 1));
        break;
      end
      if (req_addr_q[r0 + i] != 42'h2000 + ADDR_W'(i)) bad++;
      idx = req_addr_q[r0 + i] - 42'h2000;
      send_rsp(64'(idx), 64'd1);
      inf = req_total - r0 - (i + 1);
      if (inf > max_inf) max_inf = inf;
    end
    chk("t3_addr_seq", 64'(bad), 64'd0);
    chk("t3_max_inflight_ok", 64'(max_inf <= MAX_OS), 64'd1);
    wait_done(d0, 50, "t3_done_seen");
    tick(2);
    chk("t3_total_reqs", 64'(req_total - r0), 64'd100);
    chk("t3_sum", sum, 64'd5050);

    // T4: almost-full held for 10 cycles mid-REQ
    r0 = req_total; d0 = done_cnt;
    do_start(42'h3000, 16'd20);
    wait_reqs(r0 + 5, 20, "t4_pre");
    c0TxAlmFull = 1'b1;
    r1 = req_total;
    tick(10);
    chk("t4_almfull_window", 64'(req_total - r1), 64'd0);
    c0TxAlmFull = 1'b0;
    wait_reqs(r0 + 20, 40, "t4_reqs");
    bad = 0;
    for (int i = 0; i < 20; i++)
      if (req_addr_q[r0 + i] != 42'h3000 + ADDR_W'(i)) bad++;
    chk("t4_addr_seq", 64'(bad), 64'd0);
    for (int i = 0; i < 20; i++) begin
      idx = req_addr_q[r0 + i] - 42'h3000;
      send_rsp(64'(idx), 64'(2 * idx));
    end
    wait_done(d0, 30, "t4_done_seen");
    tick(2);
    chk("t4_sum", sum, 64'd570);
    chk("t4_ovf", 64'(overflow), 64'd0);

    // T5: carry out of bit 63, reverse responses, address wrap at top of space
    la[0] = 64'hFFFF_FFFF_FFFF_FFFF; lb[0] = 64'd2;
    la[1] = 64'd0; lb[1] = 64'd0;
    la[2] = 64'd0; lb[2] = 64'd0;
    r0 = req_total; d0 = done_cnt;
    do_start(42'h3FF_FFFF_FFFF, 16'd3);
    wait_reqs(r0 + 3, 20, "t5_reqs");
    chk("t5_wrap_addr", 64'(req_addr_q[r0 + 2]), 64'd1);
    for (int i = 2; i >= 0; i--) begin
      idx = req_addr_q[r0 + i] - 42'h3FF_FFFF_FFFF;
      send_rsp(la[idx[1:0]], lb[idx[1:0]]);
    end
    wait_done(d0, 20, "t5_done_seen");
    tick(2);
    chk("t5_sum", sum, 64'd1);
    chk("t5_ovf", 64'(overflow), 64'd1);

    // T6: reset after 3 of 8 requests, stale responses dropped, then a fresh run
    r0 = req_total;
    do_start(42'h4000, 16'd8);
    wait_reqs(r0 + 3, 20, "t6_three");
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("t6_rst_valid", 64'(c0_tx_valid), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 3; i++) send_rsp(64'd100, 64'd200);
    tick(3);
    chk("t6_stale_sum", sum, 64'd0);
    chk("t6_stale_busy", 64'(busy), 64'd0);
    chk("t6_req_after_rst", 64'(req_total - r0), 64'd3);
    r1 = req_total; d0 = done_cnt;
    do_start(42'h5000, 16'd2);
    wait_reqs(r1 + 2, 20, "t6_reqs");
    chk("t6_addr0", 64'(req_addr_q[r1]), 64'h5000);
    chk("t6_addr1", 64'(req_addr_q[r1 + 1]), 64'h5001);
    send_rsp(64'd10, 64'd20);
    send_rsp(64'd30, 64'd40);
    wait_done(d0, 20, "t6_done_seen");
    tick(2);
    chk("t6_sum", sum, 64'd100);
    chk("t6_ovf", 64'(overflow), 64'd0);
    chk("t6_done_pulses", 64'(done_cnt - d0), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
